// File: rtl/weight_seq.sv
// weight_seq: fetches up to 16 4x4 kernels from the tap memories and scans each over 19x19 window positions.
// Build option: define WEIGHT_SEQ_ZERO_SKIP_EN to skip the scan of kernels whose taps are all zero.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | read request for kernel k issued to the tap memories
// CAP    | tap data returned, kernel latched, scan counters cleared
// SCAN   | kernel valid, stepping x/X/y/Y on scan_ready
// DONE   | one-cycle finish pulse
module weight_seq (
  input  logic         clk,
  input  logic         xrst,
  input  logic         start,
  input  logic [4:0]   nkernel,
  output logic [3:0]   w_raddr,
  output logic         w_re,
  input  logic [127:0] w_rdata,
  output logic [127:0] kernel,
  output logic         kernel_valid,
  input  logic         scan_ready,
  output logic [1:0]   x,
  output logic [1:0]   y,
  output logic [4:0]   X,
  output logic [4:0]   Y,
  output logic         busy,
  output logic         finish
);

  localparam logic [1:0] IN_LAST  = 2'd2;
  localparam logic [4:0] POS_LAST = 5'd18;
  localparam logic [4:0] NK_MAX   = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SCAN,
    S_DONE
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   k, k_nxt;
  logic [4:0]   nk, nk_nxt;
  logic [127:0] kernel_nxt;
  logic [1:0]   x_nxt, y_nxt;
  logic [4:0]   X_nxt, Y_nxt;

  logic x_wrap, X_wrap, y_wrap, Y_wrap;
  logic scan_last;
  logic k_last;
  logic zero_kernel;

  assign x_wrap    = (x == IN_LAST);
  assign X_wrap    = (X == POS_LAST);
  assign y_wrap    = (y == IN_LAST);
  assign Y_wrap    = (Y == POS_LAST);
  assign scan_last = x_wrap & X_wrap & y_wrap & Y_wrap;
  // nk is never 0 outside IDLE, so nk-1 cannot underflow while this is used
  assign k_last    = ({1'b0, k} == (nk - 5'd1));

`ifdef WEIGHT_SEQ_ZERO_SKIP_EN
  assign zero_kernel = (w_rdata == '0);
`else
  assign zero_kernel = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    nk_nxt       = nk;
    kernel_nxt   = kernel;
    x_nxt        = x;
    y_nxt        = y;
    X_nxt        = X;
    Y_nxt        = Y;
    w_re         = 1'b0;
    w_raddr      = 4'd0;
    kernel_valid = 1'b0;
    busy         = 1'b0;
    finish       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (nkernel == 5'd0) begin
            state_nxt = S_DONE;
          end else begin
            nk_nxt    = (nkernel > NK_MAX) ? NK_MAX : nkernel;
            k_nxt     = 4'd0;
            state_nxt = S_RD;
          end
        end
      end

      S_RD: begin
        busy      = 1'b1;
        w_re      = 1'b1;
        w_raddr   = k;
        state_nxt = S_CAP;
      end

      S_CAP: begin
        busy       = 1'b1;
        kernel_nxt = w_rdata;
        x_nxt      = 2'd0;
        y_nxt      = 2'd0;
        X_nxt      = 5'd0;
        Y_nxt      = 5'd0;
        if (zero_kernel) begin
          if (k_last) begin
            state_nxt = S_DONE;
          end else begin
            k_nxt     = k + 4'd1;
            state_nxt = S_RD;
          end
        end else begin
          state_nxt = S_SCAN;
        end
      end

      S_SCAN: begin
        busy         = 1'b1;
        kernel_valid = 1'b1;
        if (scan_ready) begin
          // x innermost, then X, then y, then Y
          if (!x_wrap) begin
            x_nxt = x + 2'd1;
          end else begin
            x_nxt = 2'd0;
            if (!X_wrap) begin
              X_nxt = X + 5'd1;
            end else begin
              X_nxt = 5'd0;
              if (!y_wrap) begin
                y_nxt = y + 2'd1;
              end else begin
                y_nxt = 2'd0;
                Y_nxt = Y_wrap ? 5'd0 : (Y + 5'd1);
              end
            end
          end
          if (scan_last) begin
            if (k_last) begin
              state_nxt = S_DONE;
            end else begin
              k_nxt     = k + 4'd1;
              state_nxt = S_RD;
            end
          end
        end
      end

      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state  <= S_IDLE;
      k      <= 4'd0;
      nk     <= 5'd0;
      kernel <= '0;
      x      <= 2'd0;
      y      <= 2'd0;
      X      <= 5'd0;
      Y      <= 5'd0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      nk     <= nk_nxt;
      kernel <= kernel_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      X      <= X_nxt;
      Y      <= Y_nxt;
    end
  end

endmodule

// File: tb/tb_weight_seq.sv
// Self-checking bench for weight_seq: case table with a read/kernel scoreboard and
// hand-written sequences for scan_ready stalls, abort by reset and dropped starts.
`timescale 1ns/1ps
module tb_weight_seq;

  logic         clk = 1'b0;
  logic         xrst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   nkernel = 5'd0;
  logic [3:0]   w_raddr;
  logic         w_re;
  logic [127:0] w_rdata = '0;
  logic [127:0] kernel;
  logic         kernel_valid;
  logic         scan_ready = 1'b1;
  logic [1:0]   x, y;
  logic [4:0]   X, Y;
  logic         busy;
  logic         finish;

  weight_seq dut (
    .clk(clk), .xrst(xrst), .start(start), .nkernel(nkernel),
    .w_raddr(w_raddr), .w_re(w_re), .w_rdata(w_rdata),
    .kernel(kernel), .kernel_valid(kernel_valid), .scan_ready(scan_ready),
    .x(x), .y(y), .X(X), .Y(Y), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

`ifdef WEIGHT_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tap memories: one-cycle read latency
  logic [127:0] mem [16];
  always @(posedge clk) if (w_re) w_rdata <= mem[w_raddr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    if (n_bad <= 30) $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [127:0] pattern(input int p, input int k);
    logic [7:0]  b;
    logic [31:0] w;
    b = 8'(k);
    w = 32'h9E37_79B9 * 32'(k + 1);
    case (p)
      0:       return 128'h8070_6050_4030_2010_0FF0_E1D2_C3B4_A596;
      1:       return {16{b}};
      2:       return (k == 0) ? 128'd0 : {16{8'h81}};
      default: return {4{w}};
    endcase
  endfunction

  // scoreboard and monitor state
  logic [3:0]   exp_addr [$];
  logic [127:0] exp_kern [$];
  int cyc0 = 0, n_reads = 0, rd0 = 0, rd1 = 0, kv_first = 0, fin_cyc = 0, n_fin = 0, beats = 0;
  bit kv_prev = 1'b0, aborted = 1'b0;
  logic [1:0]   mx = 2'd0, my = 2'd0;
  logic [4:0]   mX = 5'd0, mY = 5'd0;
  logic [127:0] cur_k = '0;

  always @(negedge clk) begin
    if (w_re) begin
      n_reads++;
      if (n_reads == 1) rd0 = cyc - cyc0;
      else if (n_reads == 2) rd1 = cyc - cyc0;
      if (exp_addr.size() == 0) fail_now("unexpected_read", $sformatf("w_raddr=%0d with no read pending", w_raddr));
      else chk("w_raddr", w_raddr, exp_addr.pop_front());
    end
    if (kernel_valid && !kv_prev) begin
      if (kv_first == 0) kv_first = cyc - cyc0;
      if (exp_kern.size() == 0) fail_now("unexpected_kernel", $sformatf("kernel=%0h with none pending", kernel));
      else cur_k = exp_kern.pop_front();
      mx = 2'd0; my = 2'd0; mX = 5'd0; mY = 5'd0;
      beats = 0;
    end
    if (kernel_valid) begin
      chk("scan_pos", {Y, y, X, x}, {mY, my, mX, mx});
      chk("kernel", kernel, cur_k);
      if (scan_ready) begin
        beats++;
        if (mx != 2'd2) mx = mx + 2'd1;
        else begin
          mx = 2'd0;
          if (mX != 5'd18) mX = mX + 5'd1;
          else begin
            mX = 5'd0;
            if (my != 2'd2) my = my + 2'd1;
            else begin
              my = 2'd0;
              mY = (mY == 5'd18) ? 5'd0 : mY + 5'd1;
            end
          end
        end
      end
    end else if (kv_prev && !aborted) begin
      chk("beats_per_kernel", beats, 3249);
    end
    if (finish) begin
      n_fin++;
      fin_cyc = cyc - cyc0;
      chk("busy_at_finish", busy, 0);
    end
    kv_prev = kernel_valid;
  end

  task automatic prep();
    n_reads = 0; rd0 = 0; rd1 = 0; kv_first = 0; fin_cyc = 0; n_fin = 0;
    aborted = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctrl"}, {w_re, w_raddr, kernel_valid, busy, finish, x, y, X, Y}, 22'd0);
    chk({tag, "_kernel"}, kernel, 128'd0);
  endtask

  task automatic wait_pos(input logic [1:0] wx, input logic [4:0] wX, input logic [1:0] wy,
                          input logic [4:0] wY, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kernel_valid && x == wx && X == wX && y == wy && Y == wY) return;
    end
    fail_now(tag, "scan position not reached within cycle budget");
  endtask

  typedef struct {
    logic [4:0] nk;
    int pat;
    int reads;
    int rd0;
    int rd1;
    int kv;
    int fin;
  } case_t;

  case_t cases [5];

  task automatic run_case(input case_t c, input int idx);
    int nk_eff;
    for (int k = 0; k < 16; k++) mem[k] = pattern(c.pat, k);
    prep();
    nk_eff = (c.nk > 5'd16) ? 16 : int'(c.nk);
    for (int k = 0; k < nk_eff; k++) begin
      exp_addr.push_back(4'(k));
      if (!(SKIP && mem[k] == '0)) exp_kern.push_back(mem[k]);
    end
    @(posedge clk); #1;
    start = 1'b1; nkernel = c.nk; cyc0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < c.fin + 20 && n_fin == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk($sformatf("case%0d_finish_cycle", idx), fin_cyc, c.fin);
    chk($sformatf("case%0d_finish_count", idx), n_fin, 1);
    chk($sformatf("case%0d_reads", idx), n_reads, c.reads);
    chk($sformatf("case%0d_first_read_cycle", idx), rd0, c.rd0);
    chk($sformatf("case%0d_second_read_cycle", idx), rd1, c.rd1);
    chk($sformatf("case%0d_first_valid_cycle", idx), kv_first, c.kv);
    chk($sformatf("case%0d_addr_left", idx), exp_addr.size(), 0);
    chk($sformatf("case%0d_kernels_left", idx), exp_kern.size(), 0);
  endtask

  initial begin
    // nk, pattern, reads, 1st read, 2nd read, 1st valid, finish (cycles after start)
    cases[0] = '{5'd1,  0, 1,  1, 0,                  3,              3252};
    cases[1] = '{5'd3,  1, 3,  1, SKIP ? 3 : 3252,    SKIP ? 5 : 3,   SKIP ? 6505 : 9754};
    cases[2] = '{5'd0,  1, 0,  0, 0,                  0,              1};
    cases[3] = '{5'd2,  2, 2,  1, SKIP ? 3 : 3252,    SKIP ? 5 : 3,   SKIP ? 3254 : 6503};
    cases[4] = '{5'd20, 3, 16, 1, 3252,               3,              52017};

    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    for (int i = 0; i < 5; i++) run_case(cases[i], i);

    // stall at x=2,X=5, start while busy, then abort by reset at Y=7
    for (int k = 0; k < 16; k++) mem[k] = pattern(0, k);
    prep();
    exp_addr.push_back(4'd0);
    exp_kern.push_back(mem[0]);
    @(posedge clk); #1;
    start = 1'b1; nkernel = 5'd1; cyc0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_pos(2'd1, 5'd5, 2'd0, 5'd0, 200, "reach_x1_X5");
    @(posedge clk); #1 scan_ready = 1'b0;
    @(negedge clk); chk("hold_a", {X, x}, {5'd5, 2'd2});
    @(posedge clk); #1;
    @(negedge clk); chk("hold_b", {X, x}, {5'd5, 2'd2});
    @(posedge clk); #1 scan_ready = 1'b1;
    @(negedge clk); chk("hold_c", {X, x}, {5'd5, 2'd2});
    @(posedge clk);
    @(negedge clk); chk("resume", {X, x}, {5'd6, 2'd0});

    @(posedge clk); #1;
    start = 1'b1; nkernel = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); chk("busy_start_ignored", {busy, kernel_valid, w_re}, 3'b110);

    wait_pos(2'd0, 5'd0, 2'd0, 5'd7, 2000, "reach_Y7");
    aborted = 1'b1;
    @(posedge clk); #1;
    xrst = 1'b1; start = 1'b1; nkernel = 5'd2;
    @(posedge clk); #1;
    xrst = 1'b0; start = 1'b0;
    @(negedge clk); check_idle("abort");
    repeat (10) @(negedge clk);
    chk("abort_no_finish", n_fin, 0);
    chk("abort_reads", n_reads, 1);
    chk("abort_busy", busy, 0);

    // start landing in DONE is dropped
    prep();
    @(posedge clk); #1;
    start = 1'b1; nkernel = 5'd0; cyc0 = cyc;
    @(posedge clk); #1;
    start = 1'b1; nkernel = 5'd1;
    @(negedge clk); chk("done_finish", {finish, busy}, 2'b10);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("done_start_reads", n_reads, 0);
    chk("done_start_busy", busy, 0);
    chk("done_finish_count", n_fin, 1);
    chk("done_finish_cycle", fin_cyc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
